step_spin_controller: RTL

STEP_SPIN_CONTROLLER -- requirements
Module: step_spin_controller

---
 rtl/step_spin_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/step_spin_controller.sv
// Multi-channel stepper-motor microstep sequencer: per-channel IDLE/RUN FSM
// that issues step pulses, tracks a 5-bit electrical phase, and counts down
// (full steps << mode) microsteps, all paced by one shared period divider.
// Latency: first step max(period,1) cycles after an accepted start, then every
// max(period,1) cycles; done rides on the final step, busy drops one cycle later.
// Backpressure: none; start while busy and start+abort together are ignored.
// Ports:
//   clk, resetb            : clock, asynchronous active-low reset
//   start/abort/dir [NCH]  : per-channel move request, stop request, direction
//   mode [2*NCH]           : per-channel microstep mode (0 full .. 3 eighth)
//   steps [NCH*CNT_W]      : per-channel full-step count
//   period [DIV_W]         : shared clocks per microstep (0 treated as 1)
//   step/busy/done/aborted : per-channel registered status pulses / level
//   phase [5*NCH]          : per-channel phase in eighth-step units, mod 32
module step_spin_controller #(
  parameter int NCH   = 2,
  parameter int CNT_W = 12,
  parameter int DIV_W = 16
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [NCH-1:0]         start,
  input  logic [NCH-1:0]         abort,
  input  logic [NCH-1:0]         dir,
  input  logic [2*NCH-1:0]       mode,
  input  logic [NCH*CNT_W-1:0]   steps,
  input  logic [DIV_W-1:0]       period,
  output logic [NCH-1:0]         step,
  output logic [5*NCH-1:0]       phase,
  output logic [NCH-1:0]         busy,
  output logic [NCH-1:0]         done,
  output logic [NCH-1:0]         aborted
);

  localparam int REM_W = CNT_W + 3;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // Shared effective period; a zero period behaves as one step per clock.
  logic [DIV_W-1:0] period_m;
  assign period_m = (period == '0) ? DIV_W'(1) : period;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t           state_q;
    logic             dir_q;
    logic [1:0]       mode_q;
    logic [REM_W-1:0] rem_q;
    logic [DIV_W-1:0] div_q;
    logic [4:0]       phase_q;
    logic             step_q;
    logic             done_q;
    logic             aborted_q;

    logic [1:0]       mode_in;
    logic [CNT_W-1:0] steps_in;
    logic [REM_W-1:0] rem_ld;
    logic [4:0]       inc_acc;
    logic [4:0]       inc_run;
    logic [4:0]       phase_acc_d;
    logic [4:0]       phase_run_d;

    assign mode_in  = mode[2*c +: 2];
    assign steps_in = steps[c*CNT_W +: CNT_W];
    assign rem_ld   = REM_W'(steps_in) << mode_in;
    assign inc_acc  = 5'd8 >> mode_in;
    assign inc_run  = 5'd8 >> mode_q;
    // Phase after a step issued straight from acceptance uses the live
    // dir/mode; steps issued in RUN use the latched copies.
    assign phase_acc_d = dir[c] ? (phase_q + inc_acc) : (phase_q - inc_acc);
    assign phase_run_d = dir_q  ? (phase_q + inc_run) : (phase_q - inc_run);

    // div_q holds the number of cycles until the next step appears on the
    // output; the step register is loaded on the edge where div_q is 1, so a
    // period of 1 has to fire directly from the accepting edge.
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        state_q   <= S_IDLE;
        dir_q     <= 1'b0;
        mode_q    <= 2'd0;
        rem_q     <= '0;
        div_q     <= '0;
        phase_q   <= 5'd0;
        step_q    <= 1'b0;
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
      end else begin
        step_q    <= 1'b0;
        done_q    <= 1'b0;
        aborted_q <= 1'b0;
        case (state_q)
          S_IDLE: begin
            if (start[c] && !abort[c]) begin
              if (steps_in == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q <= S_RUN;
                dir_q   <= dir[c];
                mode_q  <= mode_in;
                if (period_m == DIV_W'(1)) begin
                  step_q  <= 1'b1;
                  phase_q <= phase_acc_d;
                  rem_q   <= rem_ld - REM_W'(1);
                  done_q  <= (rem_ld == REM_W'(1));
                  div_q   <= period_m;
                end else begin
                  rem_q <= rem_ld;
                  div_q <= period_m - DIV_W'(1);
                end
              end
            end
          end
          S_RUN: begin
            if (rem_q == '0) begin
              // Final step already out with done; this is the busy tail cycle.
              state_q <= S_IDLE;
              div_q   <= '0;
            end else if (abort[c]) begin
              // Abort outranks a step due on this edge, including the last one.
              state_q   <= S_IDLE;
              aborted_q <= 1'b1;
              rem_q     <= '0;
              div_q     <= '0;
            end else if (div_q == DIV_W'(1)) begin
              step_q  <= 1'b1;
              phase_q <= phase_run_d;
              rem_q   <= rem_q - REM_W'(1);
              done_q  <= (rem_q == REM_W'(1));
              div_q   <= period_m;
            end else begin
              div_q <= div_q - DIV_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end

    assign step[c]          = step_q;
    assign phase[5*c +: 5]  = phase_q;
    assign busy[c]          = (state_q == S_RUN);
    assign done[c]          = done_q;
    assign aborted[c]       = aborted_q;
  end

endmodule
